oscillator_phase: RTL and testbench
===================================

OSCILLATOR_PHASE -- requirements
Module: oscillator_phase

Interface
REQ-001 Parameter PHASE_WIDTH, default CONFIG::LONG_PERCENT_WIDTH, is the phase accumulator and increment width.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port enable, input, 1 bit: voice active; low forces the idle state.
REQ-005 Port sample_tick, input, 1 bit: one-cycle strobe, once per audio sample.
REQ-006 Port retrigger, input, 1 bit: one-cycle strobe that restarts the waveform at phase 0, FRONT.
REQ-007 Port increment, input, PHASE_WIDTH bits: unsigned phase step per sample, per half-period.
REQ-008 Port state, output, OSCILLATOR::oscillator_state_t: FRONT (rising half) or BACK (falling half).
REQ-009 Port phase, output, PHASE_WIDTH bits (CONFIG::long_percent_t): position within the current half-period.
REQ-010 Port phase_valid, output, 1 bit: one-cycle pulse marking an updated state/phase pair.
REQ-011 Port cycle_done, output, 1 bit: one-cycle pulse on a BACK-to-FRONT transition, i.e. a full period completed.

Function
REQ-012 The block SHALL have two internal modes: IDLE and RUN.
REQ-013 IDLE SHALL hold phase=0 and state=FRONT, and SHALL keep phase_valid=0 and cycle_done=0.
REQ-014 IDLE SHALL move to RUN on the cycle enable=1 is sampled, and SHALL load increment into the internal step register on that cycle.
REQ-015 RUN SHALL return to IDLE on the cycle enable=0 is sampled.
  - Next cycle: phase=0, state=FRONT, no pulses.
  - A sample_tick on that same cycle SHALL be discarded.
REQ-016 In RUN, on sample_tick, the block SHALL form sum = phase + step at PHASE_WIDTH+1 bits.
REQ-017 That sum SHALL be registered as follows:
  - phase <= sum[PHASE_WIDTH-1:0].
  - If sum[PHASE_WIDTH]=1 (carry), state toggles FRONT<->BACK.
  - If there is no carry, state holds.
REQ-018 phase, state and phase_valid SHALL all update on the cycle after sample_tick (one-cycle latency). phase_valid SHALL be high for exactly that one cycle.
REQ-019 cycle_done SHALL assert together with phase_valid only when the update toggles state from BACK to FRONT.
REQ-020 The step register SHALL reload from increment only at these points:
  - IDLE->RUN entry.
  - A retrigger.
  - A tick whose update produces BACK->FRONT.
  Increment changes at any other time SHALL take effect at the next period boundary, so no glitch occurs mid-period.
REQ-021 Retrigger in RUN SHALL set phase=0 and state=FRONT, and SHALL reload step, on the next cycle.
  - No phase_valid or cycle_done pulse.
  - Retrigger has priority over a simultaneous sample_tick; that tick is discarded.
REQ-022 Retrigger in IDLE SHALL have no effect.
REQ-023 Step=0 SHALL leave phase and state unchanged on a tick, but phase_valid SHALL still pulse.
REQ-024 Only one carry per tick is possible; step=2^PHASE_WIDTH-1 SHALL toggle state on every tick except the first from phase 0.
REQ-025 A sample_tick on consecutive cycles SHALL produce one update per tick, with no loss.
REQ-026 All outputs SHALL be driven directly from registers; there SHALL be no combinational input-to-output path.

Reset
REQ-027 When reset=1 is sampled, the next cycle SHALL have:
  - mode = IDLE, phase = 0, state = FRONT, step register = 0, phase_valid = 0, cycle_done = 0.
REQ-028 Reset SHALL override enable, retrigger and sample_tick, including reset asserted mid-run or coincident with a tick.

Verification (bench PHASE_WIDTH=8)
REQ-029 Basic stepping: enable=1, increment=64, 4 ticks -> phase 64,128,192,0.
  - State toggles FRONT->BACK on the 4th tick.
  - phase_valid: 4 pulses, each 1 cycle after its tick.
REQ-030 Full period: 4 more ticks -> BACK->FRONT on the 8th tick, with cycle_done=1 on exactly that cycle.
REQ-031 Deferred increment: increment changes 64->96 at phase 64 (FRONT).
  - Step stays 64 until the BACK->FRONT boundary.
  - The following ticks then advance by 96.
REQ-032 Retrigger priority: retrigger and sample_tick asserted together at phase 192 BACK -> next cycle phase=0, FRONT, phase_valid=0.
REQ-033 Carry remainder: increment=255 from phase 0.
  - Tick 1 -> phase 255, FRONT.
  - Tick 2 -> phase 254, BACK.
  - Tick 3 -> phase 253, FRONT, cycle_done=1.
REQ-034 Reset and disable mid-run: reset=1 at phase 128 BACK -> next cycle phase=0, FRONT, no pulses. Then with enable=0, ticks -> no phase_valid pulses.

Source files
------------

// File: rtl/oscillator_phase.sv
// Two-half-period phase accumulator for an oscillator voice.
// The step register reloads only at run entry, retrigger or a completed period.
module oscillator_phase #(
  parameter int unsigned PHASE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_tick,
  input  logic                   retrigger,
  input  logic [PHASE_WIDTH-1:0] increment,
  output logic                   state,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   cycle_done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mode_t;
  typedef enum logic {FRONT = 1'b0, BACK = 1'b1} half_t;

  mode_t                  mode_q, mode_d;
  half_t                  half_q, half_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] step_q, step_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic [PHASE_WIDTH:0]   sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q  <= IDLE;
      half_q  <= FRONT;
      phase_q <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      IDLE:    if (enable)  mode_d = RUN;
      RUN:     if (!enable) mode_d = IDLE;
      default: mode_d = IDLE;
    endcase
  end

  // Register next-values; outputs are taken straight from the _q flops.
  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, step_q};
    half_d  = half_q;
    phase_d = phase_q;
    step_d  = step_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (mode_q)
      IDLE: begin
        half_d  = FRONT;
        phase_d = '0;
        if (enable) step_d = increment;
      end
      RUN: begin
        if (!enable) begin
          half_d  = FRONT;
          phase_d = '0;
        end else if (retrigger) begin
          half_d  = FRONT;
          phase_d = '0;
          step_d  = increment;
        end else if (sample_tick) begin
          phase_d = sum[PHASE_WIDTH-1:0];
          valid_d = 1'b1;
          if (sum[PHASE_WIDTH]) begin
            half_d = (half_q == FRONT) ? BACK : FRONT;
            if (half_q == BACK) begin
              done_d = 1'b1;
              step_d = increment;
            end
          end
        end
      end
      default: begin
        half_d  = FRONT;
        phase_d = '0;
      end
    endcase
  end

  assign state       = half_q;
  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign cycle_done  = done_q;

endmodule

// File: tb/tb_oscillator_phase.sv
// Scoreboard bench for oscillator_phase at PHASE_WIDTH=8 with hand-computed vectors.
module tb_oscillator_phase;

  localparam int unsigned W = 8;
  localparam logic F = 1'b0;
  localparam logic B = 1'b1;

  logic         clock = 1'b0;
  logic         reset, enable, sample_tick, retrigger;
  logic [W-1:0] increment;
  logic         state;
  logic [W-1:0] phase;
  logic         phase_valid, cycle_done;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // expected {state, phase, cycle_done}
  logic [W+1:0] exp_q[$];

  oscillator_phase #(.PHASE_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sample_tick(sample_tick),
    .retrigger(retrigger), .increment(increment), .state(state), .phase(phase),
    .phase_valid(phase_valid), .cycle_done(cycle_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every phase_valid pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (phase_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_phase_valid", 1, 0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("tick_state", int'(state), int'(e[W+1]));
        check("tick_phase", int'(phase), int'(e[W:1]));
        check("tick_cycle_done", int'(cycle_done), int'(e[0]));
      end
    end else if (cycle_done) begin
      check("cycle_done_without_valid", 1, 0);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input logic st, input int ph, input logic dn);
    logic [W-1:0] p;
    p = ph[W-1:0];
    sample_tick = 1'b1;
    exp_q.push_back({st, p, dn});
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic retrig();
    retrigger = 1'b1;
    cyc();
    retrigger = 1'b0;
  endtask

  task automatic check_quiet(input string name, input int ph);
    @(negedge clock);
    check({name, "_phase"}, int'(phase), ph);
    check({name, "_state"}, int'(state), int'(F));
    check({name, "_valid"}, int'(phase_valid), 0);
    check({name, "_done"}, int'(cycle_done), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_tick = 1'b0; retrigger = 1'b0; increment = '0;
    cyc(); cyc();
    check_quiet("reset", 0);
    reset = 1'b0;
    cyc();

    // Basic stepping and full period, consecutive ticks
    enable = 1'b1; increment = 8'd64;
    cyc();
    tick(F, 64, 0); tick(F, 128, 0); tick(F, 192, 0); tick(B, 0, 0);
    tick(B, 64, 0); cyc(); tick(B, 128, 0); tick(B, 192, 0); tick(F, 0, 1);

    // Deferred increment: new value only after BACK->FRONT
    tick(F, 64, 0);
    increment = 8'd96;
    tick(F, 128, 0); tick(F, 192, 0); tick(B, 0, 0); tick(B, 64, 0);
    tick(B, 128, 0); tick(B, 192, 0); tick(F, 0, 1);
    tick(F, 96, 0); tick(F, 192, 0); tick(B, 32, 0); tick(B, 128, 0);

    // Retrigger priority over simultaneous tick at 192 BACK
    increment = 8'd64;
    retrig();
    check_quiet("retrig", 0);
    tick(F, 64, 0); tick(F, 128, 0); tick(F, 192, 0); tick(B, 0, 0);
    tick(B, 64, 0); tick(B, 128, 0); tick(B, 192, 0);
    retrigger = 1'b1; sample_tick = 1'b1;
    cyc();
    retrigger = 1'b0; sample_tick = 1'b0;
    check_quiet("retrig_prio", 0);

    // Carry remainder with maximum step
    increment = 8'd255;
    retrig();
    tick(F, 255, 0); tick(B, 254, 0); tick(F, 253, 1); tick(B, 252, 0);

    // Step of zero still pulses phase_valid
    increment = 8'd0;
    retrig();
    tick(F, 0, 0); tick(F, 0, 0);

    // Disable coincident with a tick discards the tick
    increment = 8'd64;
    retrig();
    tick(F, 64, 0);
    enable = 1'b0; sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    check_quiet("disable", 0);

    // Reset mid-run, coincident with a tick
    enable = 1'b1;
    cyc();
    tick(F, 64, 0); tick(F, 128, 0); tick(F, 192, 0); tick(B, 0, 0);
    tick(B, 64, 0); tick(B, 128, 0);
    reset = 1'b1; sample_tick = 1'b1;
    cyc();
    reset = 1'b0; sample_tick = 1'b0; enable = 1'b0;
    check_quiet("reset_midrun", 0);

    // Idle ignores ticks and retrigger
    sample_tick = 1'b1; cyc(); cyc(); cyc(); sample_tick = 1'b0;
    retrig();
    check_quiet("idle", 0);

    begin
      int unsigned budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        cyc();
        budget++;
      end
      check("scoreboard_drained", int'(exp_q.size()), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
